// File: rtl/spi_frame_master.sv
// SPI command master: serialises 10-bit RAM commands into SS_n/MOSI frames and captures read replies.
// Optional SPI_MASTER_SEQ_CHECK_EN rejects rd-data commands not preceded by an rd-addr command.
module spi_frame_master #(
    parameter int unsigned TA_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       err,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSel,
        StShift,
        StTurn,
        StRecv,
        StEnd
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  cmd_q;
    logic [7:0]  shreg;
    logic        accept;
    logic        seq_bad;
    logic        ss_n_d, mosi_d, rsp_valid_d, err_d;

    assign accept = cmd_valid && cmd_ready;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic addr_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_armed <= 1'b0;
        end else if (accept) begin
            if (cmd_data[9:8] == 2'b10) addr_armed <= 1'b1;
            else if (cmd_data[9:8] == 2'b11) addr_armed <= 1'b0;
        end
    end

    assign seq_bad = (cmd_data[9:8] == 2'b11) && !addr_armed;
`else
    assign seq_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // A rejected command takes the END slot so cmd_ready still drops for a cycle
                    if (seq_bad) begin
                        state_d = StEnd;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StStart: state_d = StSel;
            StSel: begin
                state_d = StShift;
                cnt_d   = 4'd9;
            end
            StShift: begin
                if (cnt_q == 4'd0) begin
                    if (cmd_q[9:8] == 2'b11) begin
                        state_d = StTurn;
                        cnt_d   = 4'(TA_CYCLES - 1);
                    end else begin
                        state_d = StEnd;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StTurn: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRecv;
                    cnt_d   = 4'd7;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRecv: begin
                if (cnt_q == 4'd0) begin
                    state_d     = StEnd;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StEnd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself
    always_comb begin
        ss_n_d = (state_d == StIdle) || (state_d == StEnd);
        mosi_d = 1'b0;
        case (state_d)
            StSel:   mosi_d = cmd_q[9];
            StShift: mosi_d = cmd_q[cnt_d];
            default: mosi_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            cmd_q     <= 10'd0;
            shreg     <= 8'd0;
            rsp_data  <= 8'h00;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rsp_valid <= rsp_valid_d;
            err       <= err_d;
            cmd_ready <= (state_d == StIdle);
            busy      <= (state_d != StIdle);
            SS_n      <= ss_n_d;
            MOSI      <= mosi_d;
            if (accept) cmd_q <= cmd_data;
            if (state_q == StRecv) begin
                shreg <= {shreg[6:0], MISO};
                if (cnt_q == 4'd0) rsp_data <= {shreg[6:0], MISO};
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed self-checking bench for spi_frame_master; also covers SPI_MASTER_SEQ_CHECK_EN builds.
module tb_spi_frame_master;

    localparam int TA = 2;

    logic       clk, rst, cmd_valid, MISO;
    logic [9:0] cmd_data;
    logic       cmd_ready, rsp_valid, err, busy, SS_n, MOSI;
    logic [7:0] rsp_data;

    int n_assert = 0;
    int n_fail   = 0;

    logic [9:0] words [4];
    int         accepted, frames_done, low_run, high_run, guard;
    logic       acc;
    logic [9:0] word;

    spi_frame_master #(.TA_CYCLES(TA)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .err       (err),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ss"}, SS_n, 1);
        check({tag, "_mosi"}, MOSI, 0);
        check({tag, "_rdy"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rv"}, rsp_valid, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // One full frame; k counts samples taken #1 after the accept edge and onward
    task automatic frame(input logic [9:0] cmd, input logic [7:0] rbyte);
        int  len, g;
        bit  rd;
        logic exp_mosi;
        rd  = (cmd[9:8] == 2'b11);
        len = rd ? 20 + TA : 12;
        g   = 0;
        while (!cmd_ready && g < 50) begin
            tick();
            g++;
        end
        check("frame_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = ~cmd;
        for (int k = 0; k <= len + 1; k++) begin
            if (k == 1) exp_mosi = cmd[9];
            else if (k >= 2 && k <= 11) exp_mosi = cmd[11 - k];
            else exp_mosi = 1'b0;
            check("frame_ss", SS_n, (k < len) ? 0 : 1);
            check("frame_mosi", MOSI, exp_mosi);
            check("frame_rv", rsp_valid, (rd && k == len) ? 1 : 0);
            check("frame_err", err, 0);
            check("frame_busy", busy, (k <= len) ? 1 : 0);
            check("frame_rdy", cmd_ready, (k == len + 1) ? 1 : 0);
            if (rd && k == len) check("frame_rdata", rsp_data, rbyte);
            if (k >= 12 + TA && k <= 19 + TA) MISO = rbyte[19 + TA - k];
            else MISO = 1'b1;
            if (k <= len) tick();
        end
        MISO = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 10'd0;
        MISO      = 1'b0;
        words[0]  = 10'h011;
        words[1]  = 10'h1FF;
        words[2]  = 10'h011;
        words[3]  = 10'h1FF;

        // Reset values while held in reset, then five idle cycles
        repeat (3) tick();
        check_idle("rst");
        check("rst_rdata", rsp_data, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("idle");
        end

        frame(10'h0A5, 8'h00);
        frame(10'h2C3, 8'h00);
        frame(10'h300, 8'h5A);
        frame(10'h0A5, 8'h00);
        check("rdata_hold", rsp_data, 8'h5A);

        // Back-to-back commands with cmd_valid held and data updated right after each accept
        accepted    = 0;
        frames_done = 0;
        low_run     = 0;
        high_run    = 0;
        word        = 10'd0;
        cmd_valid   = 1'b1;
        cmd_data    = words[0];
        for (int c = 0; c < 80; c++) begin
            acc = cmd_ready && cmd_valid;
            tick();
            if (acc) begin
                accepted++;
                if (accepted < 4) cmd_data = words[accepted];
                else cmd_valid = 1'b0;
            end
            if (SS_n == 1'b0) begin
                // High gap = END cycle plus the IDLE cycle in which the next command is taken
                if (low_run == 0 && frames_done > 0) check("stream_gap", high_run, 2);
                if (low_run >= 2) word = {word[8:0], MOSI};
                low_run++;
                high_run = 0;
            end else begin
                if (low_run > 0) begin
                    check("stream_low_len", low_run, 12);
                    if (frames_done < 4) check("stream_word", word, words[frames_done]);
                    frames_done++;
                    low_run = 0;
                end
                high_run++;
            end
        end
        check("stream_frames", frames_done, 4);
        check("stream_accepts", accepted, 4);
        check("stream_rdata_hold", rsp_data, 8'h5A);

        // Abort a frame at SHIFT bit 4 with an asynchronous reset
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_data  = 10'h1D7;
        tick();
        cmd_valid = 1'b0;
        repeat (7) tick();
        check("abort_pre_ss", SS_n, 0);
        check("abort_pre_mosi", MOSI, 1);
        #2 rst = 1'b1;
        #1;
        check_idle("abort_async");
        for (int i = 0; i < 2; i++) begin
            tick();
            check_idle("abort_hold");
        end
        rst = 1'b0;
        check("abort_rdata_cleared", rsp_data, 8'h00);
        tick();
        check_idle("abort_release");

`ifdef SPI_MASTER_SEQ_CHECK_EN
        // rd-data without a preceding rd-addr is consumed with an err pulse and no frame
        cmd_valid = 1'b1;
        cmd_data  = 10'h300;
        tick();
        cmd_valid = 1'b0;
        check("rej_ss", SS_n, 1);
        check("rej_err", err, 1);
        check("rej_rdy", cmd_ready, 0);
        check("rej_mosi", MOSI, 0);
        tick();
        check_idle("rej_after");
        frame(10'h0E1, 8'h00);
        frame(10'h210, 8'h00);
        frame(10'h300, 8'hC3);
`else
        frame(10'h0E1, 8'h00);
        frame(10'h300, 8'hC3);
`endif
        tick();
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
